// File: rtl/sobel_stream_ctrl.sv
// AXI4-Stream wrapper around the Sobel convolution stage: feeds the conv pipeline from s_axis,
// tags every accepted beat through the pipe, buffers results in a FWFT FIFO that drives m_axis,
// and flushes/re-synchronises the conv stage after each frame.
module sobel_stream_ctrl #(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  parameter int unsigned LATENCY         = 20,
  parameter int unsigned FIFO_DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] conv_inp_frame,
  output logic                  conv_stall,
  output logic                  conv_aresetn,
  input  logic [DATA_WIDTH-1:0] conv_out_frame,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int unsigned BPR   = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int unsigned ColW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int unsigned RowW  = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FlW   = $clog2(LATENCY + 1);
  localparam int unsigned SumW  = $clog2(FIFO_DEPTH + LATENCY + 1);
  // The incoming tag is tag stage 0; only stages 1..LATENCY-1 are registered, which lines the
  // last registered stage up with the result leaving the conv stage.
  localparam int unsigned PipeN = LATENCY - 1;

  typedef enum logic [1:0] {StRun, StFlush, StResync} state_e;

  state_e              state_q;
  logic [FlW-1:0]      flush_cnt_q;
  logic [ColW-1:0]     col_q;
  logic [RowW-1:0]     row_q;
  logic [PipeN-1:0]    tag_vld_q, tag_sof_q, tag_eol_q;
  logic [FlW-1:0]      inflight_q;
  logic [CntW-1:0]     fifo_cnt_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH+1:0] head;

  logic st_run, st_flush, st_resync;
  logic credit, advance, acc, last_col, last_row, fifo_wr, fifo_rd;
  logic [SumW-1:0] occupancy;

  assign st_run    = (state_q == StRun);
  assign st_flush  = (state_q == StFlush);
  assign st_resync = (state_q == StResync);

  // Credit covers every beat already committed to the pipe, so a FIFO write can never overflow.
  assign occupancy = SumW'(fifo_cnt_q) + SumW'(inflight_q);
  assign credit    = occupancy < SumW'(FIFO_DEPTH);
  assign advance   = ~areset & credit & ((st_run & s_axis_tvalid) | st_flush);
  assign acc       = st_run & advance;
  assign last_col  = (col_q == ColW'(BPR - 1));
  assign last_row  = (row_q == RowW'(IMAGE_DIM - 1));
  assign fifo_wr   = advance & tag_vld_q[PipeN-1];
  assign fifo_rd   = m_axis_tvalid & m_axis_tready;

  assign s_axis_tready  = ~areset & st_run & credit;
  assign conv_stall     = ~advance;
  assign conv_aresetn   = ~areset & ~st_resync;
  assign conv_inp_frame = st_run ? s_axis_tdata : '0;

  // Column/row position of the next accepted beat.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (acc) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Frame sequencer: run, flush the conv pipe with LATENCY advances, one-cycle conv reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (acc && last_col && last_row) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
          end
        end
        StFlush: begin
          if (advance) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
            if (flush_cnt_q == FlW'(LATENCY - 1)) state_q <= StResync;
          end
        end
        StResync: state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

  // Tag shift register, moving in lock-step with the conv pipeline.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      tag_vld_q <= '0;
      tag_sof_q <= '0;
      tag_eol_q <= '0;
    end else if (advance) begin
      tag_vld_q[0] <= acc;
      tag_sof_q[0] <= acc & (col_q == '0) & (row_q == '0);
      tag_eol_q[0] <= acc & last_col;
      for (int unsigned k = 1; k < PipeN; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_sof_q[k] <= tag_sof_q[k-1];
        tag_eol_q[k] <= tag_eol_q[k-1];
      end
    end
  end

  // Number of valid tags currently in the pipe.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      inflight_q <= '0;
    end else begin
      case ({acc, fifo_wr})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= {conv_out_frame, tag_sof_q[PipeN-1], tag_eol_q[PipeN-1]};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign head          = mem[rd_ptr_q];
  assign m_axis_tvalid = (fifo_cnt_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH+1:2] : '0;
  assign m_axis_tuser  = m_axis_tvalid & head[1];
  assign m_axis_tlast  = m_axis_tvalid & head[0];

  // A write into a full FIFO without a matching pop would lose a result.
  assert property (@(posedge clk) disable iff (areset)
    !(fifo_wr && !fifo_rd && fifo_cnt_q == CntW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
`timescale 1ns/1ps
module tb_sobel_stream_ctrl;

  localparam int unsigned DW    = 128;
  localparam int unsigned FRAME = 256;
  localparam int unsigned LA    = 20;
  localparam int unsigned DA    = 32;
  localparam int unsigned LB    = 6;
  localparam int unsigned DB    = 8;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] a_s_tdata, a_conv_inp, a_conv_out, a_m_tdata;
  logic a_s_tvalid, a_s_tready, a_conv_stall, a_conv_aresetn;
  logic a_m_tvalid, a_m_tready, a_m_tlast, a_m_tuser;
  logic [DW-1:0] b_s_tdata, b_conv_inp, b_conv_out, b_m_tdata;
  logic b_s_tvalid, b_s_tready, b_conv_stall, b_conv_aresetn;
  logic b_m_tvalid, b_m_tready, b_m_tlast, b_m_tuser;

  sobel_stream_ctrl #(.PIXELS_PER_BEAT(16), .IMAGE_DIM(64), .LATENCY(LA), .FIFO_DEPTH(DA)) u_a (
    .clk(clk), .areset(areset),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .conv_inp_frame(a_conv_inp), .conv_stall(a_conv_stall), .conv_aresetn(a_conv_aresetn),
    .conv_out_frame(a_conv_out),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser)
  );

  sobel_stream_ctrl #(.PIXELS_PER_BEAT(16), .IMAGE_DIM(64), .LATENCY(LB), .FIFO_DEPTH(DB)) u_b (
    .clk(clk), .areset(areset),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .conv_inp_frame(b_conv_inp), .conv_stall(b_conv_stall), .conv_aresetn(b_conv_aresetn),
    .conv_out_frame(b_conv_out),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser)
  );

  // Conv stage stubs: stall-gated delay lines of LATENCY-1 stages.
  logic [DW-1:0] a_dl [LA-1];
  logic [DW-1:0] b_dl [LB-1];
  always @(posedge clk or negedge a_conv_aresetn) begin
    if (!a_conv_aresetn) begin
      for (int k = 0; k < int'(LA) - 1; k++) a_dl[k] <= '0;
    end else if (!a_conv_stall) begin
      a_dl[0] <= a_conv_inp;
      for (int k = 1; k < int'(LA) - 1; k++) a_dl[k] <= a_dl[k-1];
    end
  end
  always @(posedge clk or negedge b_conv_aresetn) begin
    if (!b_conv_aresetn) begin
      for (int k = 0; k < int'(LB) - 1; k++) b_dl[k] <= '0;
    end else if (!b_conv_stall) begin
      b_dl[0] <= b_conv_inp;
      for (int k = 1; k < int'(LB) - 1; k++) b_dl[k] <= b_dl[k-1];
    end
  end
  assign a_conv_out = a_dl[LA-2];
  assign b_conv_out = b_dl[LB-2];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] pat(input logic [15:0] seed, input int idx);
    logic [15:0] ix;
    ix = 16'(idx);
    return {seed, ix, ~seed, ~ix, seed ^ ix, ix, seed, 16'ha5c3};
  endfunction

  // Reference model of instance A: outstanding beats, frame position and sequencer state.
  int mo = 0, mpeak = 0, mstate = 0, mfl = 0, min_idx = 0;
  always @(negedge clk) begin
    bit credit, adv, acc, pop, run, fl, rs;
    if (areset) begin
      chk("rst_s_tready", DW'(a_s_tready), DW'(0));
      chk("rst_conv_aresetn", DW'(a_conv_aresetn), DW'(0));
      chk("rst_m_tvalid", DW'(a_m_tvalid), DW'(0));
      mo = 0; mstate = 0; mfl = 0; min_idx = 0;
    end else begin
      credit = (mo < int'(DA));
      run = (mstate == 0); fl = (mstate == 1); rs = (mstate == 2);
      adv = credit && ((run && a_s_tvalid) || fl);
      chk("s_tready", DW'(a_s_tready), DW'(run && credit));
      chk("conv_stall", DW'(a_conv_stall), DW'(!adv));
      chk("conv_aresetn", DW'(a_conv_aresetn), DW'(!rs));
      if (!run) chk("conv_inp_zero", a_conv_inp, '0);
      acc = run && adv;
      pop = a_m_tvalid && a_m_tready;
      mo = mo + int'(acc) - int'(pop);
      if (mo > mpeak) mpeak = mo;
      case (mstate)
        0: if (acc) begin
          if (min_idx == int'(FRAME) - 1) begin mstate = 1; mfl = 0; min_idx = 0; end
          else min_idx++;
        end
        1: if (adv) begin mfl++; if (mfl == int'(LA)) mstate = 2; end
        default: mstate = 0;
      endcase
    end
  end

  // Drive n beats of a frame; vpct is the per-cycle tvalid probability, held until accepted.
  task automatic send(input bit sel, input logic [15:0] seed, input int n, input int vpct,
                      output int cycles);
    int i;
    bit v, hs, hold;
    i = 0; cycles = 0; hold = 1'b0;
    while (i < n && cycles < 4000) begin
      v = hold ? 1'b1 : (int'($urandom_range(99)) < vpct);
      if (sel) begin b_s_tvalid = v; b_s_tdata = pat(seed, i); end
      else begin a_s_tvalid = v; a_s_tdata = pat(seed, i); end
      @(negedge clk);
      hs = sel ? (b_s_tvalid && b_s_tready) : (a_s_tvalid && a_s_tready);
      hold = v && !hs;
      @(posedge clk);
      #1;
      cycles++;
      if (hs) i++;
    end
    if (sel) b_s_tvalid = 1'b0; else a_s_tvalid = 1'b0;
    chk("send_count", DW'(i), DW'(n));
  endtask

  // Collect one frame. rmode 0: always ready, 1: 100-cycle stall, 3: ready 1 cycle in 3.
  task automatic recv(input bit sel, input logic [15:0] seed, input int rmode);
    int j, cyc;
    bit r, v, l, u, stalled;
    logic [DW-1:0] d, held;
    j = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (j < int'(FRAME) && cyc < 6000) begin
      case (rmode)
        1:       r = !(cyc >= 40 && cyc < 140);
        3:       r = (cyc % 3 == 0);
        default: r = 1'b1;
      endcase
      if (sel) b_m_tready = r; else a_m_tready = r;
      @(negedge clk);
      v = sel ? b_m_tvalid : a_m_tvalid;
      d = sel ? b_m_tdata : a_m_tdata;
      l = sel ? b_m_tlast : a_m_tlast;
      u = sel ? b_m_tuser : a_m_tuser;
      if (stalled) begin
        chk("hold_valid", DW'(v), DW'(1));
        chk("hold_data", d, held);
      end
      if (v && r) begin
        chk("out_data", d, pat(seed, j));
        chk("out_tlast", DW'(l), DW'(j % 4 == 3));
        chk("out_tuser", DW'(u), DW'(j == 0));
        j++;
      end
      stalled = v && !r;
      held = d;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (sel) b_m_tready = 1'b1; else a_m_tready = 1'b1;
    chk("recv_count", DW'(j), DW'(FRAME));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    a_s_tvalid = 1'b0; a_s_tdata = '0; a_m_tready = 1'b1;
    b_s_tvalid = 1'b0; b_s_tdata = '0; b_m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tlast", DW'(a_m_tlast), DW'(0));
    chk("rst_tuser", DW'(a_m_tuser), DW'(0));
    chk("rst_tdata", a_m_tdata, '0);
    chk("rst_b_s_tready", DW'(b_s_tready), DW'(0));
    @(posedge clk);
    #1;
    areset = 1'b0;
    idle(2);

    // 1: full-rate ramp frame
    fork
      begin send(0, 16'h1000, FRAME, 100, c); chk("t1_cycles", DW'(c), DW'(FRAME)); end
      recv(0, 16'h1000, 0);
    join
    idle(40);
    chk("t1_empty", DW'(a_m_tvalid), DW'(0));

    // 2: downstream stall mid-frame, backpressure at full credit
    mpeak = 0;
    fork
      begin send(0, 16'h2000, FRAME, 100, c); end
      recv(0, 16'h2000, 1);
    join
    chk("t2_peak", DW'(mpeak), DW'(DA));
    idle(40);
    chk("t2_empty", DW'(a_m_tvalid), DW'(0));

    // 3: sparse input
    fork
      begin send(0, 16'h3000, FRAME, 50, c); end
      recv(0, 16'h3000, 0);
    join
    idle(40);

    // 4: back-to-back frames; second one waits out flush and resync
    fork
      begin
        send(0, 16'h4000, FRAME, 100, c);
        send(0, 16'h4100, FRAME, 100, c);
        chk("t4_cycles", DW'(c), DW'(FRAME + LA + 1));
      end
      begin recv(0, 16'h4000, 0); recv(0, 16'h4100, 0); end
    join
    idle(40);

    // 5: reset in the middle of a frame, then a fresh frame
    send(0, 16'h5000, 130, 100, c);
    areset = 1'b1;
    @(negedge clk);
    chk("t5_m_tvalid", DW'(a_m_tvalid), DW'(0));
    chk("t5_m_tlast", DW'(a_m_tlast), DW'(0));
    chk("t5_m_tuser", DW'(a_m_tuser), DW'(0));
    chk("t5_m_tdata", a_m_tdata, '0);
    chk("t5_s_tready", DW'(a_s_tready), DW'(0));
    @(posedge clk);
    #1;
    areset = 1'b0;
    idle(1);
    fork
      begin send(0, 16'h5100, FRAME, 100, c); chk("t5_cycles", DW'(c), DW'(FRAME)); end
      recv(0, 16'h5100, 0);
    join
    idle(40);
    chk("t5_empty", DW'(a_m_tvalid), DW'(0));

    // 6: minimum-depth FIFO with sparse downstream ready
    fork
      begin send(1, 16'h6000, FRAME, 100, c); end
      recv(1, 16'h6000, 3);
    join
    idle(60);
    chk("t6_empty", DW'(b_m_tvalid), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
